adxl_frame_sequencer: RTL

//  Sequences the ADXL362 SPI link at frame level: power-up wait, config-register write frames, then
//  one XY burst-read frame per sample_tick. Drives a byte-level SPI engine (mode-0 shifter) via a

---
 rtl/adxl_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adxl_frame_sequencer.sv
// -----------------------------------------------------------------------------
// adxl_frame_sequencer
// Frame-level sequencer for an ADXL362 on a byte-level SPI engine. After a
// power-up wait it writes FILTER_CTL and POWER_CTL, then runs one 6-byte
// XY burst read per accepted sample_tick. A host cfg_req re-runs both config
// frames. Every frame is followed by a chip-select-high gap.
//
// Ports
//   iclk, rst_n          clock, asynchronous active-low reset
//   sample_tick          pulse: request one XY read frame
//   cfg_req              pulse: re-run both config frames
//   eng_start/eng_tx     byte request to the SPI engine (tx held until done)
//   eng_done/eng_rx      byte complete from the engine, rx valid that cycle
//   cs_n                 ADXL362 chip select, active low
//   x_raw/y_raw          last completed XY sample, xy_valid strobes on update
//   ready                configuration complete, reads accepted
//   overrun              pulse: a sample_tick was dropped
// -----------------------------------------------------------------------------
module adxl_frame_sequencer #(
    parameter int unsigned PWRUP_TICKS  = 24000,
    parameter int unsigned CS_GAP_TICKS = 8,
    parameter logic [7:0]  FILTER_VAL   = 8'h13,
    parameter logic [7:0]  PWRCTL_VAL   = 8'h02
) (
    input  logic        iclk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic        cfg_req,
    output logic        eng_start,
    output logic [7:0]  eng_tx,
    input  logic        eng_done,
    input  logic [7:0]  eng_rx,
    output logic        cs_n,
    output logic [15:0] x_raw,
    output logic [15:0] y_raw,
    output logic        xy_valid,
    output logic        ready,
    output logic        overrun
);

    localparam logic [7:0] CMD_WRITE   = 8'h0A;
    localparam logic [7:0] CMD_READ    = 8'h0B;
    localparam logic [7:0] REG_XDATA_L = 8'h0E;
    localparam logic [7:0] REG_FILTER  = 8'h2C;
    localparam logic [7:0] REG_POWER   = 8'h2D;

    localparam int unsigned CNT_MAX = (PWRUP_TICKS > CS_GAP_TICKS) ? PWRUP_TICKS : CS_GAP_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_TICKS - 1);

    typedef enum logic [2:0] {S_PWRUP, S_CFG, S_RD, S_GAP, S_IDLE} state_t;

    state_t           r_state,  w_state;
    logic [CNT_W-1:0] r_cnt,    w_cnt;
    logic [2:0]       r_idx,    w_idx;
    logic             r_first,  w_first;       // frame just opened, first byte not yet issued
    logic             r_busy,   w_busy;        // one byte outstanding at the engine
    logic             r_cfg_k,  w_cfg_k;       // 0: FILTER_CTL frame, 1: POWER_CTL frame
    logic             r_after_cfg0, w_after_cfg0;
    logic             r_after_cfg1, w_after_cfg1;
    logic             r_cfg_pending, w_cfg_pending;
    logic             r_pending, w_pending;
    logic             r_cs_n,   w_cs_n;
    logic             r_eng_start, w_eng_start;
    logic [7:0]       r_eng_tx, w_eng_tx;
    logic [7:0]       r_xl, w_xl, r_xh, w_xh, r_yl, w_yl;
    logic [15:0]      r_x_raw, w_x_raw, r_y_raw, w_y_raw;
    logic             r_xy_valid, w_xy_valid;
    logic             r_ready,  w_ready;
    logic             r_overrun, w_overrun;

    logic w_dispatch, w_cfg_now, w_rd_now, w_cfg0_go, w_cfg1_go, w_rd_go, w_is_rd;
    logic [2:0] w_last_idx;

    function automatic logic [7:0] f_tx_byte(input logic is_rd, input logic k, input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if (is_rd) begin
            case (idx)
                3'd0:    v = CMD_READ;
                3'd1:    v = REG_XDATA_L;
                default: v = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    v = CMD_WRITE;
                3'd1:    v = k ? REG_POWER : REG_FILTER;
                default: v = k ? PWRCTL_VAL : FILTER_VAL;
            endcase
        end
        return v;
    endfunction

    always_comb begin
        // NOTE: every w_ signal gets a default first so no path leaves it unassigned (no latches).
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_idx         = r_idx;
        w_first       = r_first;
        w_busy        = r_busy;
        w_cfg_k       = r_cfg_k;
        w_after_cfg0  = r_after_cfg0;
        w_after_cfg1  = r_after_cfg1;
        w_cs_n        = r_cs_n;
        w_eng_start   = 1'b0;
        w_eng_tx      = r_eng_tx;
        w_xl          = r_xl;
        w_xh          = r_xh;
        w_yl          = r_yl;
        w_x_raw       = r_x_raw;
        w_y_raw       = r_y_raw;
        w_xy_valid    = 1'b0;
        w_ready       = r_ready;
        w_overrun     = 1'b0;
        w_pending     = r_pending;
        w_dispatch    = 1'b0;
        w_cfg0_go     = 1'b0;
        w_cfg1_go     = 1'b0;
        w_rd_go       = 1'b0;
        w_is_rd       = (r_state == S_RD);
        w_last_idx    = w_is_rd ? 3'd5 : 3'd2;
        // Same-cycle requests count, so an idle sequencer opens the frame on the next edge.
        w_cfg_now     = r_cfg_pending | cfg_req;
        w_rd_now      = r_pending | (sample_tick & r_ready);

        case (r_state)
            S_PWRUP: begin
                if (r_cnt == PWRUP_LAST) w_cfg0_go = 1'b1;
                else                     w_cnt = r_cnt + CNT_W'(1);
            end
            S_CFG, S_RD: begin
                if (r_first) begin
                    w_first     = 1'b0;
                    w_eng_start = 1'b1;
                    w_eng_tx    = f_tx_byte(w_is_rd, r_cfg_k, 3'd0);
                    w_busy      = 1'b1;
                end else if (eng_done && r_busy) begin
                    w_busy = 1'b0;
                    if (w_is_rd) begin
                        case (r_idx)
                            3'd2:    w_xl = eng_rx;
                            3'd3:    w_xh = eng_rx;
                            3'd4:    w_yl = eng_rx;
                            default: ;
                        endcase
                    end
                    if (r_idx == w_last_idx) begin
                        w_cs_n       = 1'b1;
                        w_state      = S_GAP;
                        w_cnt        = '0;
                        w_after_cfg0 = !w_is_rd && !r_cfg_k;
                        w_after_cfg1 = !w_is_rd &&  r_cfg_k;
                        if (w_is_rd) begin
                            w_x_raw    = {r_xh, r_xl};
                            w_y_raw    = {eng_rx, r_yl};
                            w_xy_valid = 1'b1;
                        end
                    end else begin
                        w_idx       = r_idx + 3'd1;
                        w_eng_start = 1'b1;
                        w_eng_tx    = f_tx_byte(w_is_rd, r_cfg_k, r_idx + 3'd1);
                        w_busy      = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) w_dispatch = 1'b1;
                else                   w_cnt = r_cnt + CNT_W'(1);
            end
            S_IDLE:  w_dispatch = 1'b1;
            default: w_state = S_PWRUP;
        endcase

        if (w_dispatch) begin
            w_after_cfg0 = 1'b0;
            w_after_cfg1 = 1'b0;
            if (w_cfg_now) begin
                w_cfg0_go = 1'b1;
            end else if (r_after_cfg0) begin
                w_cfg1_go = 1'b1;
            end else begin
                if (r_after_cfg1) w_ready = 1'b1;
                if (w_rd_now) w_rd_go = 1'b1;
                else          w_state = S_IDLE;
            end
        end

        if (w_cfg0_go || w_cfg1_go || w_rd_go) begin
            w_state = w_rd_go ? S_RD : S_CFG;
            w_cfg_k = w_cfg1_go;
            w_cs_n  = 1'b0;
            w_first = 1'b1;
            w_idx   = 3'd0;
            w_cnt   = '0;
        end
        if (w_cfg0_go) w_ready = 1'b0;

        w_cfg_pending = (r_cfg_pending | (cfg_req && r_state != S_PWRUP)) && !w_cfg0_go;

        if (w_rd_go) w_pending = 1'b0;
        if (sample_tick && r_ready) begin
            // When a held request is being served, this tick takes its place.
            if (w_rd_go)        w_pending = r_pending;
            else if (r_pending) w_overrun = 1'b1;
            else                w_pending = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_PWRUP;
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_first       <= 1'b0;
            r_busy        <= 1'b0;
            r_cfg_k       <= 1'b0;
            r_after_cfg0  <= 1'b0;
            r_after_cfg1  <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_pending     <= 1'b0;
            r_cs_n        <= 1'b1;
            r_eng_start   <= 1'b0;
            r_eng_tx      <= 8'h00;
            r_xl          <= 8'h00;
            r_xh          <= 8'h00;
            r_yl          <= 8'h00;
            r_x_raw       <= 16'h0000;
            r_y_raw       <= 16'h0000;
            r_xy_valid    <= 1'b0;
            r_ready       <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_idx         <= w_idx;
            r_first       <= w_first;
            r_busy        <= w_busy;
            r_cfg_k       <= w_cfg_k;
            r_after_cfg0  <= w_after_cfg0;
            r_after_cfg1  <= w_after_cfg1;
            r_cfg_pending <= w_cfg_pending;
            r_pending     <= w_pending;
            r_cs_n        <= w_cs_n;
            r_eng_start   <= w_eng_start;
            r_eng_tx      <= w_eng_tx;
            r_xl          <= w_xl;
            r_xh          <= w_xh;
            r_yl          <= w_yl;
            r_x_raw       <= w_x_raw;
            r_y_raw       <= w_y_raw;
            r_xy_valid    <= w_xy_valid;
            r_ready       <= w_ready;
            r_overrun     <= w_overrun;
        end
    end

    assign eng_start = r_eng_start;
    assign eng_tx    = r_eng_tx;
    assign cs_n      = r_cs_n;
    assign x_raw     = r_x_raw;
    assign y_raw     = r_y_raw;
    assign xy_valid  = r_xy_valid;
    assign ready     = r_ready;
    assign overrun   = r_overrun;

endmodule
